// File: rtl/qpu_exu_qtimeline_ctrl_if.sv
// Instruction-in / event-out bundle of the quantum timeline controller.
// master = decode stage and event queue side, slave = the controller.
interface qpu_exu_qtimeline_ctrl_if #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned QOP_W      = 28
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             i_valid;
  logic             o_ready;
  logic             i_qwait;
  logic             i_quantum;
  logic             i_halt;
  logic [TS_W-1:0]  i_interval;
  logic [QOP_W-1:0] i_qop;
  logic             i_start;
  logic             o_evt_valid;
  logic             i_evt_ready;
  logic [QOP_W-1:0] o_evt_qop;
  logic [TS_W-1:0]  o_evt_time;
  logic [TS_W-1:0]  o_now;
  logic             o_busy;
  logic             o_late;
  logic [CNT_W-1:0] o_fifo_cnt;

  modport master (
    output i_valid, i_qwait, i_quantum, i_halt, i_interval, i_qop, i_start, i_evt_ready,
    input  o_ready, o_evt_valid, o_evt_qop, o_evt_time, o_now, o_busy, o_late, o_fifo_cnt
  );

  modport slave (
    input  i_valid, i_qwait, i_quantum, i_halt, i_interval, i_qop, i_start, i_evt_ready,
    output o_ready, o_evt_valid, o_evt_qop, o_evt_time, o_now, o_busy, o_late, o_fifo_cnt
  );
endinterface

// File: rtl/qpu_exu_qtimeline_ctrl.sv
// Quantum timeline controller: stamps quantum ops with a cumulative timeline
// label and releases them from a FIFO when the wall-clock timer reaches them.
module qpu_exu_qtimeline_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned QOP_W      = 28
) (
  input logic                     clk,
  input logic                     rst,
  qpu_exu_qtimeline_ctrl_if.slave bus
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [TS_W-1:0]  mem_ts  [FIFO_DEPTH];
  logic [QOP_W-1:0] mem_qop [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [TS_W-1:0]  now, tl, head_ts, diff, push_ts;
  logic             late, full, empty, due, head_now, ready, accept;
  logic             do_qwait, do_quantum, do_halt, evt_valid, pop, start_run;

  always_comb begin
    full       = (cnt == CNT_W'(FIFO_DEPTH));
    empty      = (cnt == '0);
    head_ts    = mem_ts[rd_ptr];
    // Signed wrap-around compare: head is due when head_ts - now <= 0.
    diff       = head_ts - now;
    due        = diff[TS_W-1] | (diff == '0);
    head_now   = ~empty & (diff == '0);
    ready      = (state != DRAIN) & ~full;
    accept     = bus.i_valid & ready;
    do_qwait   = accept & bus.i_qwait;
    do_quantum = accept & ~bus.i_qwait & bus.i_quantum;
    do_halt    = accept & ~bus.i_qwait & ~bus.i_quantum & bus.i_halt;
    push_ts    = tl + bus.i_interval;
    evt_valid  = (state != IDLE) & ~empty & due;
    pop        = evt_valid & bus.i_evt_ready;
    start_run  = (state == IDLE) & bus.i_start;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start) state_nxt = RUN;
      RUN:     if (do_halt) state_nxt = DRAIN;
      DRAIN:   if (empty || (pop && cnt == CNT_W'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now    <= '0;
      tl     <= '0;
      late   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Timer freezes only while the head sits exactly on the current tick.
      if (start_run) now <= '0;
      else if (state != IDLE && !head_now) now <= now + TS_W'(1);

      if (start_run) late <= 1'b0;
      else if (pop && diff != '0) late <= 1'b1;

      // qwait and quantum both advance tl to tl + interval.
      if (state == DRAIN && state_nxt == IDLE) tl <= '0;
      else if (do_qwait || do_quantum) tl <= push_ts;

      if (do_quantum) wr_ptr <= wr_ptr + AW'(1);
      if (pop)        rd_ptr <= rd_ptr + AW'(1);
      if (do_quantum && !pop)      cnt <= cnt + CNT_W'(1);
      else if (!do_quantum && pop) cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_quantum) begin
      mem_ts[wr_ptr]  <= push_ts;
      mem_qop[wr_ptr] <= bus.i_qop;
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_evt_valid = evt_valid;
  assign bus.o_evt_qop   = mem_qop[rd_ptr];
  assign bus.o_evt_time  = head_ts;
  assign bus.o_now       = now;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_late      = late;
  assign bus.o_fifo_cnt  = cnt;
endmodule

// File: tb/tb_qpu_exu_qtimeline_ctrl.sv
// Bench for qpu_exu_qtimeline_ctrl: directed scenarios plus a randomized run
// checked against a queue-based timeline model.
module tb_qpu_exu_qtimeline_ctrl;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TSW   = 32;
  localparam int unsigned QW    = 28;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qpu_exu_qtimeline_ctrl_if #(.FIFO_DEPTH(DEPTH), .TS_W(TSW), .QOP_W(QW)) bus ();
  qpu_exu_qtimeline_ctrl #(.FIFO_DEPTH(DEPTH), .TS_W(TSW), .QOP_W(QW)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [QW-1:0] QA = 28'hA0A0A0A;
  localparam logic [QW-1:0] QB = 28'hB0B0B0B;
  localparam logic [QW-1:0] QC = 28'hC0C0C0C;

  typedef struct {
    logic [TSW-1:0] ts;
    logic [QW-1:0]  qop;
  } ev_t;

  task automatic idle_inputs();
    bus.i_valid = 0; bus.i_qwait = 0; bus.i_quantum = 0; bus.i_halt = 0;
    bus.i_interval = '0; bus.i_qop = '0; bus.i_start = 0; bus.i_evt_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    cyc();
    bus.i_start = 1'b0;
  endtask

  // Holds an instruction on the bus until it is accepted (bounded wait).
  task automatic issue(input bit qw, input bit qu, input bit ha,
                       input logic [TSW-1:0] iv, input logic [QW-1:0] qop);
    bit done = 0;
    bus.i_valid = 1; bus.i_qwait = qw; bus.i_quantum = qu; bus.i_halt = ha;
    bus.i_interval = iv; bus.i_qop = qop;
    for (int n = 0; n < 60 && !done; n++) begin
      if (bus.o_ready) done = 1;
      cyc();
    end
    bus.i_valid = 0; bus.i_qwait = 0; bus.i_quantum = 0; bus.i_halt = 0;
    total++;
    if (!done) begin bad++; $display("FAIL issue_accept: accepted=0 required=1"); end
  endtask

  task automatic preload_abc();
    issue(0, 1, 0, 1, QA);
    issue(0, 1, 0, 0, QB);
    issue(1, 0, 0, 5, '0);
    issue(0, 1, 0, 0, QC);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.o_busy !== 1'b0)     begin bad++; $display("FAIL rst0_busy: got=%0d want=0", bus.o_busy); end
    total++; if (bus.o_evt_valid !== 1'b0) begin bad++; $display("FAIL rst0_valid: got=%0d want=0", bus.o_evt_valid); end
    total++; if (bus.o_fifo_cnt !== '0)   begin bad++; $display("FAIL rst0_cnt: got=%0d want=0", bus.o_fifo_cnt); end
    total++; if (bus.o_ready !== 1'b1)    begin bad++; $display("FAIL rst0_ready: got=%0d want=1", bus.o_ready); end
    pulse_start();
    issue(1, 0, 0, 100, '0);
    for (int i = 0; i < 3; i++) issue(0, 1, 0, 0, QA + QW'(i));
    total++; if (bus.o_fifo_cnt !== 4'd3) begin bad++; $display("FAIL rst_pre_cnt: got=%0d want=3", bus.o_fifo_cnt); end
    rst = 1'b1;
    cyc();
    total++; if (bus.o_busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got=%0d want=0", bus.o_busy); end
    total++; if (bus.o_evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%0d want=0", bus.o_evt_valid); end
    total++; if (bus.o_fifo_cnt !== '0)    begin bad++; $display("FAIL rst_cnt: got=%0d want=0", bus.o_fifo_cnt); end
    total++; if (bus.o_now !== '0)         begin bad++; $display("FAIL rst_now: got=%0d want=0", bus.o_now); end
    total++; if (bus.o_late !== 1'b0)      begin bad++; $display("FAIL rst_late: got=%0d want=0", bus.o_late); end
    rst = 1'b0;
    cyc();
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL rst_after_busy: got=%0d want=0", bus.o_busy); end
  endtask

  task automatic test_preload_run();
    logic [QW-1:0]  p_qop  [3];
    logic [TSW-1:0] p_now  [3];
    logic [TSW-1:0] p_time [3];
    logic [QW-1:0]  e_qop  [3];
    logic [TSW-1:0] e_t    [3];
    int np = 0;
    e_qop = '{QA, QB, QC};
    e_t   = '{1, 1, 6};
    do_reset();
    preload_abc();
    bus.i_evt_ready = 1;
    pulse_start();
    for (int n = 0; n < 40 && np < 3; n++) begin
      if (bus.o_evt_valid && bus.i_evt_ready) begin
        p_qop[np] = bus.o_evt_qop; p_now[np] = bus.o_now; p_time[np] = bus.o_evt_time; np++;
      end
      cyc();
    end
    total++; if (np != 3) begin bad++; $display("FAIL run_pops: got=%0d want=3", np); end
    for (int i = 0; i < np; i++) begin
      total++; if (p_qop[i] !== e_qop[i]) begin bad++; $display("FAIL run_qop%0d: got=%h want=%h", i, p_qop[i], e_qop[i]); end
      total++; if (p_now[i] !== e_t[i])   begin bad++; $display("FAIL run_now%0d: got=%0d want=%0d", i, p_now[i], e_t[i]); end
      total++; if (p_time[i] !== e_t[i])  begin bad++; $display("FAIL run_time%0d: got=%0d want=%0d", i, p_time[i], e_t[i]); end
    end
    total++; if (bus.o_late !== 1'b0) begin bad++; $display("FAIL run_late: got=%0d want=0", bus.o_late); end
  endtask

  task automatic test_backpressure();
    int np = 0;
    int w = 0;
    logic [QW-1:0] p_qop [2];
    do_reset();
    preload_abc();
    bus.i_evt_ready = 0;
    pulse_start();
    while (!bus.o_evt_valid && w < 10) begin cyc(); w++; end
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.o_evt_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d: got=%0d want=1", k, bus.o_evt_valid); end
      total++; if (bus.o_now !== 32'd1)       begin bad++; $display("FAIL bp_now%0d: got=%0d want=1", k, bus.o_now); end
      total++; if (bus.o_evt_qop !== QA)      begin bad++; $display("FAIL bp_qop%0d: got=%h want=%h", k, bus.o_evt_qop, QA); end
      cyc();
    end
    bus.i_evt_ready = 1;
    for (int n = 0; n < 10 && np < 2; n++) begin
      if (bus.o_evt_valid) begin p_qop[np] = bus.o_evt_qop; np++; end
      cyc();
    end
    total++; if (np != 2) begin bad++; $display("FAIL bp_pops: got=%0d want=2", np); end
    total++; if (np == 2 && (p_qop[0] !== QA || p_qop[1] !== QB)) begin
      bad++; $display("FAIL bp_order: got=%h,%h want=%h,%h", p_qop[0], p_qop[1], QA, QB);
    end
    cyc();
    total++; if (bus.o_now !== 32'd2) begin bad++; $display("FAIL bp_resume: got=%0d want=2", bus.o_now); end
  endtask

  task automatic test_full();
    bit seen_pop = 0;
    bit early = 0;
    int acc = 0;
    int pops = 0;
    logic [QW-1:0] last = '0;
    do_reset();
    for (int i = 0; i < 8; i++) issue(0, 1, 0, 0, 28'h100 + QW'(i));
    total++; if (bus.o_fifo_cnt !== 4'd8) begin bad++; $display("FAIL full_cnt: got=%0d want=8", bus.o_fifo_cnt); end
    total++; if (bus.o_ready !== 1'b0)    begin bad++; $display("FAIL full_ready: got=%0d want=0", bus.o_ready); end
    bus.i_valid = 1; bus.i_quantum = 1; bus.i_interval = 0; bus.i_qop = 28'h1FF;
    for (int k = 0; k < 3; k++) cyc();
    total++; if (bus.o_fifo_cnt !== 4'd8) begin bad++; $display("FAIL full_hold: got=%0d want=8", bus.o_fifo_cnt); end
    pulse_start();
    bus.i_evt_ready = 1;
    for (int n = 0; n < 40 && pops < 9; n++) begin
      if (bus.i_valid && bus.o_ready) begin
        if (!seen_pop) early = 1;
        acc++;
      end
      if (bus.o_evt_valid) begin seen_pop = 1; pops++; last = bus.o_evt_qop; end
      cyc();
      if (acc > 0) begin bus.i_valid = 0; bus.i_quantum = 0; end
    end
    total++; if (early)     begin bad++; $display("FAIL full_early: accepted_before_pop=1 required=0"); end
    total++; if (acc != 1)  begin bad++; $display("FAIL full_acc: got=%0d want=1", acc); end
    total++; if (pops != 9) begin bad++; $display("FAIL full_pops: got=%0d want=9", pops); end
    total++; if (last !== 28'h1FF) begin bad++; $display("FAIL full_last: got=%h want=1ff", last); end
    total++; if (bus.o_late !== 1'b0) begin bad++; $display("FAIL full_late: got=%0d want=0", bus.o_late); end
  endtask

  task automatic test_starvation();
    int w = 0;
    do_reset();
    bus.i_evt_ready = 1;
    pulse_start();
    while (bus.o_now != 32'd20 && w < 40) begin cyc(); w++; end
    total++; if (bus.o_now !== 32'd20) begin bad++; $display("FAIL starve_reach: got=%0d want=20", bus.o_now); end
    issue(0, 1, 0, 3, 28'h5A5);
    total++; if (bus.o_evt_valid !== 1'b1) begin bad++; $display("FAIL starve_valid: got=%0d want=1", bus.o_evt_valid); end
    total++; if (bus.o_evt_time !== 32'd3) begin bad++; $display("FAIL starve_time: got=%0d want=3", bus.o_evt_time); end
    total++; if (bus.o_evt_qop !== 28'h5A5) begin bad++; $display("FAIL starve_qop: got=%h want=5a5", bus.o_evt_qop); end
    total++; if (bus.o_late !== 1'b0) begin bad++; $display("FAIL starve_prelate: got=%0d want=0", bus.o_late); end
    cyc();
    total++; if (bus.o_late !== 1'b1) begin bad++; $display("FAIL starve_late: got=%0d want=1", bus.o_late); end
    issue(0, 0, 1, 0, '0);
    cyc();
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL starve_idle: got=%0d want=0", bus.o_busy); end
    total++; if (bus.o_late !== 1'b1) begin bad++; $display("FAIL starve_sticky: got=%0d want=1", bus.o_late); end
    pulse_start();
    total++; if (bus.o_late !== 1'b0) begin bad++; $display("FAIL starve_clear: got=%0d want=0", bus.o_late); end
  endtask

  task automatic test_halt_drain();
    int np = 0;
    logic [TSW-1:0] p_now [2];
    logic [TSW-1:0] p_time [2];
    do_reset();
    issue(0, 1, 0, 2, 28'hD1);
    issue(0, 1, 0, 2, 28'hD2);
    bus.i_evt_ready = 1;
    pulse_start();
    issue(0, 0, 1, 0, '0);
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL halt_ready: got=%0d want=0", bus.o_ready); end
    total++; if (bus.o_busy !== 1'b1)  begin bad++; $display("FAIL halt_busy: got=%0d want=1", bus.o_busy); end
    for (int n = 0; n < 20 && np < 2; n++) begin
      if (bus.o_evt_valid) begin p_now[np] = bus.o_now; p_time[np] = bus.o_evt_time; np++; end
      cyc();
    end
    total++; if (np != 2) begin bad++; $display("FAIL halt_pops: got=%0d want=2", np); end
    for (int i = 0; i < np; i++) begin
      total++; if (p_now[i] !== 32'(2 * (i + 1)))  begin bad++; $display("FAIL halt_now%0d: got=%0d want=%0d", i, p_now[i], 2 * (i + 1)); end
      total++; if (p_time[i] !== 32'(2 * (i + 1))) begin bad++; $display("FAIL halt_time%0d: got=%0d want=%0d", i, p_time[i], 2 * (i + 1)); end
    end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL halt_idle: got=%0d want=0", bus.o_busy); end
    issue(0, 1, 0, 0, 28'hE0);
    pulse_start();
    total++; if (bus.o_evt_valid !== 1'b1) begin bad++; $display("FAIL halt_tl_valid: got=%0d want=1", bus.o_evt_valid); end
    total++; if (bus.o_evt_time !== '0)    begin bad++; $display("FAIL halt_tl_time: got=%0d want=0", bus.o_evt_time); end
  endtask

  task automatic test_random();
    ev_t mq[$];
    int m_mode = 0;
    logic [TSW-1:0] m_now = '0;
    logic [TSW-1:0] m_tl = '0;
    bit m_late = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bit m_ready, m_ev, acc, pop, hold;
      int mode_n;
      logic signed [TSW-1:0] d;
      ev_t e;
      bus.i_valid     = ($urandom_range(0, 99) < 60);
      bus.i_qwait     = ($urandom_range(0, 99) < 20);
      bus.i_quantum   = ($urandom_range(0, 99) < 60);
      bus.i_halt      = ($urandom_range(0, 99) < 15);
      bus.i_interval  = ($urandom_range(0, 99) < 2) ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 4));
      bus.i_qop       = QW'($urandom);
      bus.i_start     = ($urandom_range(0, 99) < 6);
      bus.i_evt_ready = ($urandom_range(0, 99) < 70);

      m_ready = (m_mode != 2) && (mq.size() < DEPTH);
      d = (mq.size() > 0) ? mq[0].ts - m_now : 1;
      m_ev = (m_mode != 0) && (mq.size() > 0) && (d <= 0);
      total++; if (bus.o_ready !== m_ready)   begin bad++; $display("FAIL rnd_ready c%0d: got=%0d want=%0d", c, bus.o_ready, m_ready); end
      total++; if (bus.o_evt_valid !== m_ev)  begin bad++; $display("FAIL rnd_valid c%0d: got=%0d want=%0d", c, bus.o_evt_valid, m_ev); end
      if (m_ev) begin
        total++; if (bus.o_evt_qop !== mq[0].qop || bus.o_evt_time !== mq[0].ts) begin
          bad++; $display("FAIL rnd_evt c%0d: got=%h@%0d want=%h@%0d", c, bus.o_evt_qop, bus.o_evt_time, mq[0].qop, mq[0].ts);
        end
      end
      total++; if (bus.o_now !== m_now)       begin bad++; $display("FAIL rnd_now c%0d: got=%0d want=%0d", c, bus.o_now, m_now); end
      total++; if (bus.o_busy !== (m_mode != 0)) begin bad++; $display("FAIL rnd_busy c%0d: got=%0d want=%0d", c, bus.o_busy, m_mode != 0); end
      total++; if (bus.o_late !== m_late)     begin bad++; $display("FAIL rnd_late c%0d: got=%0d want=%0d", c, bus.o_late, m_late); end
      total++; if (int'(bus.o_fifo_cnt) != mq.size()) begin bad++; $display("FAIL rnd_cnt c%0d: got=%0d want=%0d", c, bus.o_fifo_cnt, mq.size()); end

      acc  = bus.i_valid && m_ready;
      pop  = m_ev && bus.i_evt_ready;
      hold = (mq.size() > 0) && (mq[0].ts == m_now);
      mode_n = m_mode;
      if (pop) begin
        if (mq[0].ts != m_now) m_late = 1;
        mq.delete(0);
      end
      if (m_mode != 0 && !hold) m_now = m_now + 1;
      if (acc) begin
        if (bus.i_qwait) m_tl = m_tl + bus.i_interval;
        else if (bus.i_quantum) begin
          e.ts = m_tl + bus.i_interval; e.qop = bus.i_qop;
          mq.push_back(e);
          m_tl = e.ts;
        end else if (bus.i_halt && m_mode == 1) mode_n = 2;
      end
      if (m_mode == 0 && bus.i_start) begin mode_n = 1; m_now = '0; m_late = 0; end
      if (m_mode == 2 && mq.size() == 0) begin mode_n = 0; m_tl = '0; end
      m_mode = mode_n;
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_preload_run();
    test_backpressure();
    test_full();
    test_starvation();
    test_halt_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qpu_exu_qtimeline_ctrl.md
Name: qpu_exu_qtimeline_ctrl

Overview:
- Timing controller placed after the quantum decode stage in the EXU.
- Accepts decoded qwait, quantum and halt instructions and keeps a cumulative timeline label (tl) for them.
- Buffers quantum operations in a timestamped FIFO and releases each one to the downstream quantum event queue when the wall-clock timer reaches its timestamp.
- All operations in one timepoint are released as a back-to-back bundle while the timer is frozen.

Parameters:
- FIFO_DEPTH, 8: number of timestamped event entries (power of 2).
- TS_W, 32: width of timer, timeline label and timestamps.
- QOP_W, 28: width of the quantum op payload ({opcode1,rs1-or-0} and {opcode2,rs2-or-0}, 14+14 bits).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_valid  in  1  decoded instruction valid
- o_ready  out  1  instruction accepted when i_valid & o_ready
- i_qwait  in  1  instruction is qwait
- i_quantum  in  1  instruction is a quantum op
- i_halt  in  1  instruction is halt
- i_interval  in  TS_W  timepoint interval: w-imm for qwait, PI (0..7) for quantum
- i_qop  in  QOP_W  quantum op payload
- i_start  in  1  start timeline (pulse)
- o_evt_valid  out  1  event output valid
- i_evt_ready  in  1  downstream accepts event
- o_evt_qop  out  QOP_W  event payload
- o_evt_time  out  TS_W  event timestamp
- o_now  out  TS_W  current timer value
- o_busy  out  1  state != IDLE
- o_late  out  1  sticky: an event was emitted after its due time
- o_fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Asserting rst forces state=IDLE, now=0, tl=0, FIFO empty, o_evt_valid=0, o_late=0, o_busy=0. This holds mid-operation too; all queued events are discarded.
- States:
  - IDLE: timer held. Instructions are accepted (preload).
  - RUN: timer active.
  - DRAIN: after halt, no new instructions.
- Transitions:
  - IDLE→RUN on i_start. This clears now to 0 and clears o_late; tl and FIFO are kept. i_start in RUN or DRAIN is ignored.
  - RUN→DRAIN on an accepted halt.
  - DRAIN→IDLE on the cycle after the last FIFO entry is popped, or immediately if the FIFO is empty. Entering IDLE clears tl to 0; now holds its value.
- o_ready:
  - Equals ~full in IDLE and RUN; 0 in DRAIN.
  - No bypass: a pop in the same cycle does not free a slot for the current cycle.
- Accepted qwait: tl <= tl + i_interval. Nothing is pushed.
- Accepted quantum: ts = tl + i_interval; push {ts, i_qop}; tl <= ts.
- Accepted halt in IDLE: ignored (no state change).
- Decode priority when more than one type is set: qwait > quantum > halt. Only the winning type is acted on.
- Arithmetic: all additions are modulo 2^TS_W. Due test uses the signed difference d = head_ts - now (TS_W-bit two's complement); the head is due when d <= 0.
- Emission:
  - o_evt_valid = (state != IDLE) & ~empty & due. It is registered-path, so an entry is visible no earlier than the cycle after its push.
  - o_evt_qop and o_evt_time come from the FIFO head.
  - Pop on o_evt_valid & i_evt_ready.
  - If the popped entry has head_ts != now, set o_late. It stays set until i_start or rst.
- Timer (RUN and DRAIN):
  - now increments by 1 per cycle, except it holds while the FIFO head has head_ts == now.
  - This freezes time while a timepoint bundle is emitted or back-pressured.
  - Late heads (d < 0) do not freeze the timer.
- Simultaneous events:
  - Push and pop in one cycle: occupancy is unchanged.
  - Push to an empty FIFO of an already-due entry: emitted the next cycle.

Test Plan:
- Reset: drive rst high mid-RUN with 3 queued entries → next cycle o_busy=0, o_evt_valid=0, o_fifo_cnt=0, o_now=0, o_late=0.
- Preload then run: in IDLE push quantum PI=1 qop A, quantum PI=0 qop B, qwait 5, quantum PI=0 qop C, then pulse i_start with i_evt_ready=1 → A emitted at now=1; B on the next cycle still at now=1; C at now=6 with o_evt_time=6; o_late=0.
- Backpressure: hold i_evt_ready=0 while A (ts=1) is valid for 4 cycles → o_evt_valid stays 1, o_now stays 1, payload stable. Release ready → A and then B pop, timer resumes.
- Full: push 8 quantum ops in IDLE → o_fifo_cnt=8, o_ready=0. A 9th i_valid is held unaccepted until a pop occurs in RUN.
- Starvation: start with an empty FIFO, wait until now=20, push quantum PI=3 with tl=0 → emitted the next cycle with o_evt_time=3 and o_late=1; the next i_start clears o_late.
- Halt drain: 2 entries queued (ts 2, 4), accept halt at now=0 → o_ready=0, both entries emitted at now 2 and 4, then state IDLE, o_busy=0, tl=0.
